lfsr7_rng_arbiter: RTL

Shares one 7-bit Galois LFSR random source among NREQ requesters. A round-robin arbiter grants at most one draw per cycle, and the LFSR advances only on a granted draw, so no value is ever delivered twice. The block also supports software seed load with a zero-seed guard and flags completion of each 127-draw period. It sits between the random-number consumers (test-pattern and backoff logic) and the LFSR datapath.

---
 rtl/lfsr_pkg.sv | 13 +
 rtl/lfsr7_rng_arbiter_if.sv | 31 +++
 rtl/lfsr7_core.sv | 29 ++
 rtl/lfsr7_rng_arbiter.sv | 95 +++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: width, reset value, period and the Galois step function.
package lfsr_pkg;

    localparam int unsigned LFSR_W      = 7;
    localparam logic [6:0]  LFSR_RESET  = 7'h01;
    localparam int unsigned LFSR_PERIOD = 127;

    // One Galois step, right-shifting with taps folded into bits 5..3 and fed into bit 6.
    function automatic logic [LFSR_W-1:0] lfsr7_next(input logic [LFSR_W-1:0] s);
        return {s[0], s[6] ^ s[0], s[5] ^ s[0], s[4] ^ s[0], s[3], s[2], s[1]};
    endfunction

endpackage

// File: rtl/lfsr7_rng_arbiter_if.sv
// Requester-side bus of the shared LFSR random source.
//   master: consumer side (drives seed_en, seed_val, req; sees grant/response/state)
//   slave : arbiter side (drives gnt, resp_*, period_wrap, state)
interface lfsr7_rng_arbiter_if
    import lfsr_pkg::*;
#(
    parameter int unsigned NREQ = 4
);
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic              seed_en;
    logic [LFSR_W-1:0] seed_val;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   gnt;
    logic              resp_val;
    logic [IDW-1:0]    resp_id;
    logic [LFSR_W-1:0] resp_data;
    logic              period_wrap;
    logic [LFSR_W-1:0] state;

    modport master (
        output seed_en, seed_val, req,
        input  gnt, resp_val, resp_id, resp_data, period_wrap, state
    );

    modport slave (
        input  seed_en, seed_val, req,
        output gnt, resp_val, resp_id, resp_data, period_wrap, state
    );

endinterface

// File: rtl/lfsr7_core.sv
// 7-bit Galois LFSR state register with seed load (zero-seed guard) and step enable.
//   clk, reset : clock, synchronous active-high reset
//   load       : load load_val this cycle (wins over step)
//   load_val   : seed; 0 is replaced by the reset value
//   step       : advance one LFSR step
//   state      : current LFSR state
module lfsr7_core
    import lfsr_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    input  logic              step,
    output logic [LFSR_W-1:0] state
);

    // All-zero is a lock-up state, so a zero seed falls back to the reset value.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LFSR_RESET;
        end else if (load) begin
            state <= (load_val == '0) ? LFSR_RESET : load_val;
        end else if (step) begin
            state <= lfsr7_next(state);
        end
    end

endmodule

// File: rtl/lfsr7_rng_arbiter.sv
// Round-robin arbiter sharing one 7-bit LFSR among NREQ requesters; at most one draw per cycle.
//   clk, reset : clock, synchronous active-high reset
//   bus.seed_en/seed_val : seed load, has priority over requests (no grant that cycle)
//   bus.req    : per-requester draw requests
//   bus.gnt    : combinational one-hot grant
//   bus.resp_val/resp_id/resp_data : registered response for last cycle's grant
//   bus.period_wrap : registered, last grant was the 127th draw since reset/seed
//   bus.state  : current LFSR state
module lfsr7_rng_arbiter
    import lfsr_pkg::*;
#(
    parameter int unsigned NREQ = 4
)
(
    input  logic               clk,
    input  logic               reset,
    lfsr7_rng_arbiter_if.slave bus
);

    localparam int unsigned IDW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [6:0]  DRAW_LAST = 7'(LFSR_PERIOD - 1);

    logic [IDW-1:0]    rr_ptr;
    logic [IDW-1:0]    gnt_idx;
    logic              found;
    logic              draw;
    logic [NREQ-1:0]   gnt_c;
    logic [LFSR_W-1:0] lfsr_state;
    logic [LFSR_W-1:0] draw_cnt;
    logic              resp_val_q;
    logic [IDW-1:0]    resp_id_q;
    logic [LFSR_W-1:0] resp_data_q;
    logic              period_wrap_q;

    // Modulo-NREQ index, correct for non-power-of-2 NREQ.
    function automatic logic [IDW-1:0] wrap_idx(input int unsigned v);
        return IDW'(v % NREQ);
    endfunction

    // First set request searching upward from rr_ptr; seed load suppresses the grant.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!found && bus.req[wrap_idx(32'(rr_ptr) + k)]) begin
                found   = 1'b1;
                gnt_idx = wrap_idx(32'(rr_ptr) + k);
            end
        end
        draw  = found && !bus.seed_en;
        gnt_c = draw ? (NREQ'(1) << gnt_idx) : '0;
    end

    lfsr7_core u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (bus.seed_en),
        .load_val (bus.seed_val),
        .step     (draw),
        .state    (lfsr_state)
    );

    // Pointer, draw counter and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr        <= '0;
            draw_cnt      <= '0;
            resp_val_q    <= 1'b0;
            resp_id_q     <= '0;
            resp_data_q   <= '0;
            period_wrap_q <= 1'b0;
        end else begin
            resp_val_q    <= draw;
            period_wrap_q <= draw && (draw_cnt == DRAW_LAST);
            if (draw) begin
                rr_ptr      <= wrap_idx(32'(gnt_idx) + 32'd1);
                resp_id_q   <= gnt_idx;
                resp_data_q <= lfsr_state;
            end
            if (bus.seed_en) begin
                draw_cnt <= '0;
            end else if (draw) begin
                draw_cnt <= (draw_cnt == DRAW_LAST) ? '0 : draw_cnt + 7'd1;
            end
        end
    end

    assign bus.gnt         = gnt_c;
    assign bus.resp_val    = resp_val_q;
    assign bus.resp_id     = resp_id_q;
    assign bus.resp_data   = resp_data_q;
    assign bus.period_wrap = period_wrap_q;
    assign bus.state       = lfsr_state;

endmodule
